// File: rtl/ram_responder.sv
// Word-addressed 32-bit RAM behind an MAR/MDR pair; request accepted in IDLE, mem_ready after WAIT_STATES+1 cycles.
// No backpressure: read/write are ignored while busy, and read+write together in IDLE is flagged on err.
module ram_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mar_addr,
    input  logic [31:0]       mdr_data,
    input  logic              read,
    input  logic              write,
    output logic [31:0]       mdata_in,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         wait_cnt;
    logic [3:0]         wait_cnt_nxt;
    logic               accept;
    logic               illegal;
    logic               do_access;

    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        data_q;
    logic               op_wr_q;

    // Storage has no reset so that contents survive a reset pulse.
    logic [31:0]        mem [2**ADDR_W];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        illegal      = 1'b0;
        do_access    = 1'b0;
        case (state)
            IDLE: begin
                if (read ^ write) begin
                    accept       = 1'b1;
                    wait_cnt_nxt = WS;
                    state_nxt    = (WS == 4'd0) ? ACCESS : WAIT;
                end else if (read && write) begin
                    illegal = 1'b1;
                end
            end
            WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt <= 4'd1) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                do_access = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q   <= '0;
            data_q   <= 32'h0;
            op_wr_q  <= 1'b0;
            mdata_in <= 32'h0;
            err      <= 1'b0;
        end else begin
            err <= illegal;
            if (accept) begin
                addr_q  <= mar_addr;
                data_q  <= mdr_data;
                op_wr_q <= write;
            end
            if (do_access && !op_wr_q) begin
                mdata_in <= mem[addr_q];
            end
        end
    end

    // do_access is only high in ACCESS, which an asserted reset has already left.
    always_ff @(posedge clock) begin
        if (do_access && op_wr_q) begin
            mem[addr_q] <= data_q;
        end
    end

    assign busy      = (state != IDLE);
    assign mem_ready = (state == DONE);

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench: one responder with two wait states, one with zero wait states.
module tb_ram_responder;

    logic        clock;
    logic        reset;

    logic [8:0]  mar_addr;
    logic [31:0] mdr_data;
    logic        read;
    logic        write;
    logic [31:0] mdata_in;
    logic        mem_ready;
    logic        busy;
    logic        err;

    logic [8:0]  z_addr;
    logic [31:0] z_data;
    logic        z_read;
    logic        z_write;
    logic [31:0] z_mdata;
    logic        z_ready;
    logic        z_busy;
    logic        z_err;

    int          n_assert;
    int          n_fail;
    logic [31:0] last_rd;

    ram_responder #(.ADDR_W(9), .WAIT_STATES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .mar_addr  (mar_addr),
        .mdr_data  (mdr_data),
        .read      (read),
        .write     (write),
        .mdata_in  (mdata_in),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err       (err)
    );

    ram_responder #(.ADDR_W(9), .WAIT_STATES(0)) dut0 (
        .clock     (clock),
        .reset     (reset),
        .mar_addr  (z_addr),
        .mdr_data  (z_data),
        .read      (z_read),
        .write     (z_write),
        .mdata_in  (z_mdata),
        .mem_ready (z_ready),
        .busy      (z_busy),
        .err       (z_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction on the two-wait-state instance; address/data are
    // scrambled right after acceptance so only the latched copies can be used.
    task automatic xact(input logic rd, input logic [8:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input string tag);
        mar_addr = a;
        mdr_data = d;
        read     = rd;
        write    = ~rd;
        step();
        read     = 1'b0;
        write    = 1'b0;
        mar_addr = ~a;
        mdr_data = ~d;
        chk({tag, " busy@k"}, 32'(busy), 32'd1);
        step();
        chk({tag, " ready@k+1"}, 32'(mem_ready), 32'd0);
        step();
        chk({tag, " ready@k+2"}, 32'(mem_ready), 32'd0);
        step();
        chk({tag, " ready@k+3"}, 32'(mem_ready), 32'd1);
        if (rd) last_rd = exp_rd;
        chk({tag, " mdata@k+3"}, mdata_in, last_rd);
        step();
        chk({tag, " ready@k+4"}, 32'(mem_ready), 32'd0);
        chk({tag, " busy@k+4"}, 32'(busy), 32'd0);
    endtask

    task automatic zxact(input logic rd, input logic [8:0] a, input logic [31:0] d,
                         input logic [31:0] exp_md, input string tag);
        z_addr  = a;
        z_data  = d;
        z_read  = rd;
        z_write = ~rd;
        step();
        z_read  = 1'b0;
        z_write = 1'b0;
        z_addr  = ~a;
        chk({tag, " busy@k"}, 32'(z_busy), 32'd1);
        chk({tag, " ready@k"}, 32'(z_ready), 32'd0);
        step();
        chk({tag, " ready@k+1"}, 32'(z_ready), 32'd1);
        chk({tag, " mdata@k+1"}, z_mdata, exp_md);
        step();
        chk({tag, " ready@k+2"}, 32'(z_ready), 32'd0);
        chk({tag, " busy@k+2"}, 32'(z_busy), 32'd0);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        last_rd  = 32'h0;
        reset    = 1'b0;
        mar_addr = '0;
        mdr_data = '0;
        read     = 1'b0;
        write    = 1'b0;
        z_addr   = '0;
        z_data   = '0;
        z_read   = 1'b0;
        z_write  = 1'b0;

        #1;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ready", 32'(mem_ready), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst mdata", mdata_in, 32'h0);
        step();
        step();
        reset = 1'b1;

        // Write then read back, first request right after reset release.
        xact(1'b0, 9'd5, 32'hDEADBEEF, 32'h0, "wr5");
        xact(1'b1, 9'd5, 32'h0, 32'hDEADBEEF, "rd5");

        // read and write together in IDLE.
        read  = 1'b1;
        write = 1'b1;
        step();
        read  = 1'b0;
        write = 1'b0;
        chk("illegal err", 32'(err), 32'd1);
        chk("illegal busy", 32'(busy), 32'd0);
        chk("illegal mdata", mdata_in, 32'hDEADBEEF);
        step();
        chk("illegal err clr", 32'(err), 32'd0);
        chk("illegal busy2", 32'(busy), 32'd0);

        // Requests during WAIT of a read are ignored.
        xact(1'b0, 9'd9, 32'h11111111, 32'h0, "wr9");
        mar_addr = 9'd9;
        read     = 1'b1;
        step();
        read     = 1'b0;
        write    = 1'b1;
        mdr_data = 32'h22222222;
        step();
        chk("busy wr ign", 32'(busy), 32'd1);
        read  = 1'b1;
        step();
        chk("busy both no err", 32'(err), 32'd0);
        read  = 1'b0;
        write = 1'b0;
        step();
        chk("busy rd ready", 32'(mem_ready), 32'd1);
        chk("busy rd mdata", mdata_in, 32'h11111111);
        step();
        chk("busy rd idle", 32'(busy), 32'd0);
        xact(1'b1, 9'd9, 32'h0, 32'h11111111, "rd9 again");

        // Address latching: neighbour 21 must not be disturbed by a write to 20.
        xact(1'b0, 9'd21, 32'h55555555, 32'h0, "wr21");
        xact(1'b0, 9'd20, 32'hCAFEF00D, 32'h0, "wr20");
        xact(1'b1, 9'd20, 32'h0, 32'hCAFEF00D, "rd20");
        xact(1'b1, 9'd21, 32'h0, 32'h55555555, "rd21");

        // Reset during WAIT aborts the write.
        xact(1'b0, 9'd7, 32'hA5A5A5A5, 32'h0, "wr7 old");
        mar_addr = 9'd7;
        mdr_data = 32'h12345678;
        write    = 1'b1;
        step();
        write    = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst ready", 32'(mem_ready), 32'd0);
        chk("midrst err", 32'(err), 32'd0);
        chk("midrst mdata", mdata_in, 32'h0);
        last_rd = 32'h0;
        step();
        step();
        step();
        reset = 1'b1;
        xact(1'b1, 9'd7, 32'h0, 32'hA5A5A5A5, "rd7 kept");

        // Zero wait states at the top address.
        zxact(1'b0, 9'd511, 32'hFFFFFFFF, 32'h0, "z wr511");
        zxact(1'b1, 9'd511, 32'h0, 32'hFFFFFFFF, "z rd511");
        chk("z err", 32'(z_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
